// File: rtl/split_radio_deframer.sv
// split_radio_deframer: deframes a two-lane split-radio dibit stream into payload bytes behind a sync word.
// Latency: DataValid rises 4 clocks after the last bit of a byte is captured by the first synchronizer flop.
// Backpressure: DataValid/DataReady on a registered FIFO; a byte arriving while full is dropped and Overflow sticks.
// Optional feature macro LINK_RX_CRC_EN: trailing CRC-8 byte checked in CHECK, result on FrameOk/FrameErr.
module split_radio_deframer #(
  parameter logic [15:0] SYNC_WORD  = 16'hB5A3,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic       Clock100Mhz,
  input  logic       Reset,
  input  logic       Received1236,
  input  logic       Received5478,
  output logic [7:0] DataOut,
  output logic       DataLast,
  output logic       DataValid,
  input  logic       DataReady,
  output logic       InFrame,
  output logic       Overflow,
  output logic       FrameOk,
  output logic       FrameErr
);

  // Pointer and occupancy widths; occupancy needs one extra bit to express "full".
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    HUNT    = 2'd0,
    LENGTH  = 2'd1,
    PAYLOAD = 2'd2,
    CHECK   = 2'd3
  } state_t;

  // ---------------------------------------------------------------------------
  // Input synchronizers and hunt register
  // ---------------------------------------------------------------------------
  logic        sync1_a;
  logic        sync2_a;
  logic        sync1_b;
  logic        sync2_b;
  logic [1:0]  rx_dibit;
  logic [15:0] hunt;
  logic [1:0]  cur_dibit;

  // Lane A carries the earlier bit of each dibit.
  assign rx_dibit = {sync2_a, sync2_b};

  // The framer consumes the newest dibit from the hunt register so that the
  // sync match and the first length dibit line up on consecutive cycles.
  assign cur_dibit = hunt[1:0];

  // Two-flop synchronizers on both asynchronous lanes.
  always_ff @(posedge Clock100Mhz) begin
    if (Reset) begin
      sync1_a <= 1'b0;
      sync2_a <= 1'b0;
      sync1_b <= 1'b0;
      sync2_b <= 1'b0;
    end else begin
      sync1_a <= Received1236;
      sync2_a <= sync1_a;
      sync1_b <= Received5478;
      sync2_b <= sync1_b;
    end
  end

  // Shift one dibit per cycle, MSB first, into the hunt register.
  always_ff @(posedge Clock100Mhz) begin
    if (Reset) begin
      hunt <= '0;
    end else begin
      hunt <= {hunt[13:0], rx_dibit};
    end
  end

  // ---------------------------------------------------------------------------
  // Framing state machine
  // ---------------------------------------------------------------------------
  state_t     state;
  logic [1:0] dcnt;
  logic [5:0] shreg;
  logic [7:0] cur_byte;
  logic [7:0] rem;
  logic       push_vld;
  logic [7:0] push_dat;
  logic       push_last;
  logic       byte_done;

  // Byte formed by the three held dibits plus the one arriving this cycle.
  assign cur_byte  = {shreg, cur_dibit};
  assign byte_done = (dcnt == 2'd3);

  // Sequence HUNT -> LENGTH -> PAYLOAD (-> CHECK) -> HUNT; sync matches outside HUNT are ignored.
  always_ff @(posedge Clock100Mhz) begin
    if (Reset) begin
      state     <= HUNT;
      dcnt      <= '0;
      shreg     <= '0;
      rem       <= '0;
      push_vld  <= 1'b0;
      push_dat  <= '0;
      push_last <= 1'b0;
    end else begin
      push_vld <= 1'b0;
      case (state)
        HUNT: begin
          dcnt <= '0;
          if (hunt == SYNC_WORD) begin
            state <= LENGTH;
          end
        end
        LENGTH: begin
          shreg <= cur_byte[5:0];
          dcnt  <= dcnt + 2'd1;
          if (byte_done) begin
            rem   <= cur_byte;
            // A zero-length frame carries nothing, not even a check byte.
            state <= (cur_byte == 8'd0) ? HUNT : PAYLOAD;
          end
        end
        PAYLOAD: begin
          shreg <= cur_byte[5:0];
          dcnt  <= dcnt + 2'd1;
          if (byte_done) begin
            push_vld  <= 1'b1;
            push_dat  <= cur_byte;
            push_last <= (rem == 8'd1);
            rem       <= rem - 8'd1;
            if (rem == 8'd1) begin
`ifdef LINK_RX_CRC_EN
              state <= CHECK;
`else
              state <= HUNT;
`endif
            end
          end
        end
`ifdef LINK_RX_CRC_EN
        CHECK: begin
          shreg <= cur_byte[5:0];
          dcnt  <= dcnt + 2'd1;
          if (byte_done) begin
            state <= HUNT;
          end
        end
`endif
        default: begin
          state <= HUNT;
        end
      endcase
    end
  end

  assign InFrame = (state != HUNT);

  // ---------------------------------------------------------------------------
  // Frame check
  // ---------------------------------------------------------------------------
`ifdef LINK_RX_CRC_EN
  logic [7:0] crc;
  logic       frame_ok;
  logic       frame_err;

  // CRC-8, polynomial 0x07, MSB first, one whole byte per call.
  function automatic logic [7:0] crc8_step(input logic [7:0] c, input logic [7:0] d);
    logic [7:0] r;
    r = c ^ d;
    for (int i = 0; i < 8; i++) begin
      r = r[7] ? ((r << 1) ^ 8'h07) : (r << 1);
    end
    return r;
  endfunction

  // Accumulate over length and payload; compare against the trailing byte in CHECK.
  always_ff @(posedge Clock100Mhz) begin
    if (Reset) begin
      crc       <= '0;
      frame_ok  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      frame_ok  <= 1'b0;
      frame_err <= 1'b0;
      if (state == HUNT) begin
        crc <= '0;
      end else if (byte_done) begin
        if (state == CHECK) begin
          if (cur_byte == crc) begin
            frame_ok <= 1'b1;
          end else begin
            frame_err <= 1'b1;
          end
        end else begin
          crc <= crc8_step(crc, cur_byte);
        end
      end
    end
  end

  assign FrameOk  = frame_ok;
  assign FrameErr = frame_err;
`else
  assign FrameOk  = 1'b0;
  assign FrameErr = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Output FIFO (registered, no fall-through)
  // ---------------------------------------------------------------------------
  logic [8:0]    mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] cnt;
  logic [8:0]    head;
  logic [7:0]    hold_dat;
  logic          hold_last;
  logic          ovf;
  logic          fifo_full;
  logic          fifo_empty;
  logic          do_pop;
  logic          do_push;

  assign fifo_full  = (cnt == FULL_CNT);
  assign fifo_empty = (cnt == '0);
  assign do_pop     = !fifo_empty && DataReady;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign do_push    = push_vld && (!fifo_full || do_pop);
  assign head       = mem[rd_ptr];

  // Storage write; contents need no reset because occupancy gates visibility.
  always_ff @(posedge Clock100Mhz) begin
    if (do_push) begin
      mem[wr_ptr] <= {push_last, push_dat};
    end
  end

  // Pointers, occupancy, sticky overflow and the last-popped hold register.
  always_ff @(posedge Clock100Mhz) begin
    if (Reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      cnt       <= '0;
      hold_dat  <= '0;
      hold_last <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr    <= rd_ptr + 1'b1;
        hold_dat  <= head[7:0];
        hold_last <= head[8];
      end
      if (push_vld && fifo_full && !do_pop) begin
        ovf <= 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  // When empty, keep presenting the last byte handed out (zero after reset).
  assign DataOut   = fifo_empty ? hold_dat  : head[7:0];
  assign DataLast  = fifo_empty ? hold_last : head[8];
  assign DataValid = !fifo_empty;
  assign Overflow  = ovf;

endmodule
